// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/DRAIN/HALT halt sequencer.
// Define FETCH_PERF_CNT_EN to add the StallCnt/FlushCnt performance counter outputs.
//
// state | meaning
// RUN   | normal fetch, PC advances or redirects
// DRAIN | halt word seen, PC held, bubbles issued for DRAIN_CYCLES cycles
// HALT  | fetch stopped until reset, redirects ignored
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        Stall_F,
    input  logic        Stall_D,
    input  logic        Flush_D,
    input  logic [2:0]  PC_Src_S,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] JrTarget,
    input  logic [31:0] Instr_IM,
    output logic [31:0] PC_F,
    output logic [31:0] Instr_D,
    output logic [31:0] PCPlus4_D,
    output logic        Valid_D,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt,
`endif
    output logic        Halted
);

    typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_HALT = 2'd2} state_t;

    localparam logic [3:0] LP_DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_instr, r_pcp4;
    logic        r_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_src_redirect;
    logic        w_redirect;
    logic        w_halt_detect;

    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_src_redirect = (PC_Src_S == 3'b001) || (PC_Src_S == 3'b010) || (PC_Src_S == 3'b011);
    assign w_redirect     = w_src_redirect && (r_state != S_HALT);
    assign w_halt_detect  = (r_state == S_RUN) && (Instr_IM == HALT_WORD) && !Stall_F && !w_src_redirect;

    always_comb begin
        w_target = JrTarget;
        case (PC_Src_S)
            3'b001:  w_target = BranchTarget;
            3'b010:  w_target = JumpTarget;
            default: w_target = JrTarget;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_RUN: begin
                if (w_halt_detect) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = 4'd0;
                end
            end
            S_DRAIN: begin
                if (w_redirect) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt == LP_DRAIN_LAST) begin
                    w_state_nxt = S_HALT;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_HALT;
            end
        endcase
    end

    // The PC also holds on the edge that detects the halt word, so it parks on that address.
    always_comb begin
        w_pc_nxt = w_pc_plus4;
        if (r_state == S_HALT)
            w_pc_nxt = r_pc;
        else if (w_redirect)
            w_pc_nxt = w_target;
        else if ((r_state == S_DRAIN) || w_halt_detect)
            w_pc_nxt = r_pc;
        else if (Stall_F)
            w_pc_nxt = r_pc;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            r_pc <= RESET_PC;
        else
            r_pc <= w_pc_nxt;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_instr <= 32'd0;
            r_pcp4  <= 32'd0;
            r_valid <= 1'b0;
        end else if (Flush_D) begin
            r_instr <= 32'd0;
            r_pcp4  <= 32'd0;
            r_valid <= 1'b0;
        end else if (!Stall_D) begin
            if ((r_state != S_RUN) || w_halt_detect) begin
                r_instr <= 32'd0;
                r_valid <= 1'b0;
            end else begin
                r_instr <= Instr_IM;
                r_pcp4  <= w_pc_plus4;
                r_valid <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (Stall_F && (r_state == S_RUN) && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (Flush_D && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`endif

    assign PC_F      = r_pc;
    assign Instr_D   = r_instr;
    assign PCPlus4_D = r_pcp4;
    assign Valid_D   = r_valid;
    assign Halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD    = 32'hFFFF_FFFF;
    localparam int unsigned DRAIN_CYCLES = 4;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        Stall_F, Stall_D, Flush_D;
    logic [2:0]  PC_Src_S;
    logic [31:0] BranchTarget, JumpTarget, JrTarget, Instr_IM;
    logic [31:0] PC_F, Instr_D, PCPlus4_D;
    logic        Valid_D, Halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] StallCnt, FlushCnt;
`endif

    fetch_stage #(
        .RESET_PC(RESET_PC), .HALT_WORD(HALT_WORD), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D),
        .PC_Src_S(PC_Src_S),
        .BranchTarget(BranchTarget), .JumpTarget(JumpTarget), .JrTarget(JrTarget),
        .Instr_IM(Instr_IM),
        .PC_F(PC_F), .Instr_D(Instr_D), .PCPlus4_D(PCPlus4_D), .Valid_D(Valid_D),
`ifdef FETCH_PERF_CNT_EN
        .StallCnt(StallCnt), .FlushCnt(FlushCnt),
`endif
        .Halted(Halted)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: halt progress kept as "drain cycles remaining" rather than a state machine.
    logic [31:0] m_pc, m_instr, m_pcp4, m_stall_cnt, m_flush_cnt;
    logic        m_valid, m_halted;
    int          m_drain_left;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_instr = 0; m_pcp4 = 0; m_valid = 0; m_halted = 0;
        m_drain_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    task automatic compare_all();
        chk("pc_f", PC_F, m_pc);
        chk("instr_d", Instr_D, m_instr);
        chk("pcplus4_d", PCPlus4_D, m_pcp4);
        chk("valid_d", {31'd0, Valid_D}, {31'd0, m_valid});
        chk("halted", {31'd0, Halted}, {31'd0, m_halted});
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt", StallCnt, m_stall_cnt);
        chk("flush_cnt", FlushCnt, m_flush_cnt);
`endif
    endtask

    task automatic step(input logic sf, input logic sd, input logic fl, input logic [2:0] src,
                        input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jr,
                        input logic [31:0] ins);
        logic        redir, busy, detect;
        logic [31:0] tgt;
        Stall_F = sf; Stall_D = sd; Flush_D = fl; PC_Src_S = src;
        BranchTarget = bt; JumpTarget = jt; JrTarget = jr; Instr_IM = ins;
        redir  = !m_halted && (src >= 3'd1) && (src <= 3'd3);
        tgt    = (src == 3'd1) ? bt : (src == 3'd2) ? jt : jr;
        busy   = (m_drain_left > 0);
        detect = !m_halted && !busy && (ins == HALT_WORD) && !sf && !redir;
        @(posedge CLK);
        if (!m_halted && !busy && sf && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
        if (fl && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
        if (fl) begin
            m_instr = 0; m_pcp4 = 0; m_valid = 0;
        end else if (!sd) begin
            if (m_halted || busy || detect) begin
                m_instr = 0; m_valid = 0;
            end else begin
                m_instr = ins; m_pcp4 = m_pc + 32'd4; m_valid = 1;
            end
        end
        if (!m_halted) begin
            if (redir) m_pc = tgt;
            else if (!busy && !detect && !sf) m_pc = m_pc + 32'd4;
        end
        if (detect) m_drain_left = DRAIN_CYCLES;
        else if (busy) begin
            if (redir) m_drain_left = 0;
            else begin
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1;
            end
        end
        #1;
        compare_all();
    endtask

    // Pulls reset between clock edges and checks the asynchronous clear before releasing it.
    task automatic async_reset(input string tag);
        RESET_N = 1'b0;
        #1;
        chk({tag, "_pc"}, PC_F, RESET_PC);
        chk({tag, "_instr"}, Instr_D, 32'd0);
        chk({tag, "_pcp4"}, PCPlus4_D, 32'd0);
        chk({tag, "_valid"}, {31'd0, Valid_D}, 32'd0);
        chk({tag, "_halted"}, {31'd0, Halted}, 32'd0);
        model_reset();
        #1;
        RESET_N = 1'b1;
    endtask

    task automatic idle(input logic [31:0] ins);
        step(0, 0, 0, 3'd0, 0, 0, 0, ins);
    endtask

    initial begin
        logic        sf, sd, fl;
        logic [2:0]  src;
        logic [31:0] t0, t1, t2, ins;

        RESET_N = 1'b0; Stall_F = 0; Stall_D = 0; Flush_D = 0; PC_Src_S = 0;
        BranchTarget = 0; JumpTarget = 0; JrTarget = 0; Instr_IM = 0;
        model_reset();
        #12;
        chk("rst_pc", PC_F, RESET_PC);
        chk("rst_valid", {31'd0, Valid_D}, 32'd0);
        chk("rst_halted", {31'd0, Halted}, 32'd0);
        RESET_N = 1'b1;

        // Straight-line fetch
        idle(32'h2008_0005);
        chk("seq_pc1", PC_F, 32'h4);
        chk("seq_instr", Instr_D, 32'h2008_0005);
        chk("seq_pcp4", PCPlus4_D, 32'h4);
        chk("seq_valid", {31'd0, Valid_D}, 32'd1);
        idle(32'h2008_0005);
        chk("seq_pc2", PC_F, 32'h8);

        // Two-cycle stall at PC 8
        step(1, 1, 0, 3'd0, 0, 0, 0, 32'h1111_1111);
        step(1, 1, 0, 3'd0, 0, 0, 0, 32'h2222_2222);
        chk("stall_pc", PC_F, 32'h8);
        chk("stall_instr", Instr_D, 32'h2008_0005);
        chk("stall_pcp4", PCPlus4_D, 32'h8);
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt2", StallCnt, 32'd2);
`endif

        // Branch with flush while stalled
        step(1, 0, 1, 3'd1, 32'h40, 0, 0, 32'h3333_3333);
        chk("br_pc", PC_F, 32'h40);
        chk("br_valid", {31'd0, Valid_D}, 32'd0);
        chk("br_instr", Instr_D, 32'd0);

        // Halt sequence at 0x20
        step(0, 0, 0, 3'd2, 0, 32'h20, 0, 32'h0);
        chk("jmp_pc", PC_F, 32'h20);
        idle(HALT_WORD);
        chk("hw_pc", PC_F, 32'h20);
        chk("hw_valid", {31'd0, Valid_D}, 32'd0);
        for (int i = 0; i < int'(DRAIN_CYCLES) - 1; i++) idle(32'h0);
        chk("drain_not_halted", {31'd0, Halted}, 32'd0);
        idle(32'h0);
        chk("halted", {31'd0, Halted}, 32'd1);
        step(0, 0, 0, 3'd2, 0, 32'h80, 0, 32'h0);
        chk("halt_ignore_pc", PC_F, 32'h20);

        // Drain aborted by JR
        async_reset("rst_halt");
        idle(HALT_WORD);
        step(0, 0, 0, 3'd3, 0, 0, 32'h100, 32'h0);
        chk("abort_pc", PC_F, 32'h100);
        for (int i = 0; i < int'(DRAIN_CYCLES) + 2; i++) idle(32'h0);
        chk("abort_halted", {31'd0, Halted}, 32'd0);

        // PC wrap
        step(0, 0, 0, 3'd1, 32'hFFFF_FFFC, 0, 0, 32'h0);
        idle(32'h1234_5678);
        chk("wrap_pc", PC_F, 32'h0);
        chk("wrap_pcp4", PCPlus4_D, 32'h0);
        async_reset("rst_mid");

        // Randomized phases, each started with an asynchronous reset
        for (int ph = 0; ph < 8; ph++) begin
            for (int c = 0; c < 250; c++) begin
                sf  = ($urandom_range(0, 3) == 0);
                sd  = ($urandom_range(0, 4) == 0);
                fl  = ($urandom_range(0, 5) == 0);
                src = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 2) != 0) src = 3'd0;
                t0 = $urandom; t0[1:0] = 2'b00;
                t1 = $urandom; t1[1:0] = 2'b00;
                t2 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : 32'h0;
                if (t2 == 32'h0) begin t2 = $urandom; t2[1:0] = 2'b00; end
                ins = ($urandom_range(0, 15) == 0) ? HALT_WORD : $urandom;
                step(sf, sd, fl, src, t0, t1, t2, ins);
            end
            async_reset("rst_phase");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter HALT_WORD, default 32'hFFFF_FFFF, instruction encoding that starts the halt sequence.
REQ-003 Parameter DRAIN_CYCLES, default 4, cycles spent in DRAIN before HALT (range 1..15).
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 Stall_F  in  1  hold PC this cycle.
REQ-007 Stall_D  in  1  hold IF/ID register this cycle.
REQ-008 Flush_D  in  1  clear IF/ID register this cycle.
REQ-009 PC_Src_S  in  3  next-PC select: 000 PC+4, 001 BranchTarget, 010 JumpTarget, 011 JrTarget; 100-111 treated as 000.
REQ-010 BranchTarget / JumpTarget / JrTarget  in  32 each  redirect addresses.
REQ-011 Instr_IM  in  32  instruction memory read data for PC_F, valid in the same cycle.
REQ-012 PC_F  out  32  current fetch address.
REQ-013 Instr_D / PCPlus4_D  out  32 each  IF/ID register contents.
REQ-014 Valid_D  out  1  IF/ID holds a real fetched instruction.
REQ-015 Halted  out  1  fetch permanently stopped.

Function
REQ-016 Three states: RUN, DRAIN, HALT.
REQ-017 PC next-value priority: HALT hold > redirect (PC_Src_S selects non-sequential) > DRAIN hold > Stall_F hold > PC_F+4.
REQ-018 A redirect SHALL load its target even when Stall_F=1.
REQ-019 PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-020 IF/ID priority: Flush_D clear (Instr_D=0, Valid_D=0, PCPlus4_D=0) > Stall_D hold > DRAIN/HALT load bubble (Instr_D=0, Valid_D=0) > load Instr_IM, PC_F+4, Valid_D=1.
REQ-021 RUN->DRAIN when Instr_IM==HALT_WORD, Stall_F=0, PC_Src_S selects PC+4; HALT_WORD itself is loaded into IF/ID as a bubble, not as Instr_D.
REQ-022 DRAIN: 4-bit counter from 0, increments each cycle; at DRAIN_CYCLES-1 go HALT.
REQ-023 A redirect in DRAIN aborts drain: state->RUN, counter->0, PC loads target.
REQ-024 HALT is terminal until reset; Halted=1 only in HALT; redirects ignored.
REQ-025 Latency: Instr_IM captured into Instr_D one edge after it is presented; PC redirect visible on PC_F one edge after PC_Src_S asserted.
REQ-026 Outputs are registered except none; PC_F drives instruction memory directly.

Reset
REQ-027 RESET_N low asynchronously forces PC_F=RESET_PC, Instr_D=0, PCPlus4_D=0, Valid_D=0, Halted=0, state RUN, counter 0, performance counters 0.
REQ-028 Reset asserted mid-DRAIN or in HALT returns to RUN at RESET_PC on first edge after release.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN defined: add outputs StallCnt and FlushCnt (32 bits each, out), counting cycles with Stall_F=1 in RUN and cycles with Flush_D=1 respectively, saturating at 32'hFFFF_FFFF.
REQ-030 Macro undefined: those ports and counters do not exist; all other behaviour identical.

Verification
REQ-031 Reset release, Instr_IM=32'h2008_0005, no stall -> PC_F 0,4,8; Instr_D=32'h2008_0005, PCPlus4_D=4, Valid_D=1 after first edge.
REQ-032 Stall_F=Stall_D=1 for 2 cycles at PC_F=8 -> PC_F stays 8, Instr_D/PCPlus4_D unchanged, StallCnt=2 (macro on).
REQ-033 PC_Src_S=001, BranchTarget=32'h40, Flush_D=1, Stall_F=1 -> next PC_F=32'h40, Valid_D=0, Instr_D=0.
REQ-034 Instr_IM=HALT_WORD at PC_F=32'h20, DRAIN_CYCLES=4 -> PC_F held 32'h20, Valid_D=0, Halted=1 exactly 4 edges later; later PC_Src_S=010 ignored.
REQ-035 HALT_WORD fetched, then PC_Src_S=011, JrTarget=32'h100 during DRAIN -> state RUN, PC_F=32'h100, Halted stays 0.
REQ-036 PC_F=32'hFFFF_FFFC, no stall -> PC_F=0, PCPlus4_D=0; RESET_N pulsed low between edges -> outputs reset immediately.
